aemb2_xregf: RTL and testbench
==============================

AEMB2_XREGF -- requirements
Module: aemb2_xregf

Interface
REQ-001 SHALL have parameter THR_W, default 1, meaning log2 of the hardware thread count; legal values are 1..3, giving 2..8 banks of 32 registers.
REQ-002 SHALL have parameter SEXT_EN, default 1, meaning the sign-extension load mode is present; when 0, sext_i is ignored.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port ena_i, input, 1 bit: pipeline advance enable.
REQ-006 SHALL have port rd_thr_i, input, THR_W bits: thread selected for operand reads.
REQ-007 SHALL have ports ra_i, rb_i and rd_i, input, 5 bits each: operand read addresses.
REQ-008 SHALL have ports rega_o, regb_o and regd_o, output, 32 bits each: registered operand data.
REQ-009 SHALL have port wr_thr_i, input, THR_W bits: writeback thread.
REQ-010 SHALL have port wr_i, input, 5 bits: writeback register address.
REQ-011 SHALL have port wr_src_i, input, 3 bits: writeback source; 0=ALU, 1=link PC, 2=load, 3=multiplier, 7=no write, any other value=no write.
REQ-012 SHALL have ports res_i and mul_i, input, 32 bits each: ALU result and multiplier result.
REQ-013 SHALL have port pclnk_i, input, 30 bits [31:2]: link PC.
REQ-014 SHALL have port sel_i, input, 4 bits: load byte-lane select.
REQ-015 SHALL have port sext_i, input, 1 bit: sign-extend a sub-word load.
REQ-016 SHALL have port dwb_dat_i, input, 32 bits, and port dwb_ack_i, input, 1 bit: data bus read data and acknowledge.
REQ-017 SHALL have port busy_o, output, 1 bit: clear sweep in progress.

Function
REQ-018 SHALL be a two-state FSM, SWEEP and RUN; rst_i forces SWEEP with the sweep counter at 0.
REQ-019 In SWEEP, SHALL write 0 to register entry {thread, index} = counter in every bank, one entry per cycle, then increment the counter.
REQ-020 SHALL move from SWEEP to RUN in the cycle after the counter reaches 32*2^THR_W-1; sweep length is exactly 32*2^THR_W cycles.
REQ-021 busy_o SHALL be 1 in SWEEP and 0 in RUN.
REQ-022 During SWEEP, ena_i, writebacks and operand reads SHALL be ignored, and the outputs SHALL hold 0.
REQ-023 In RUN with ena_i=1, rega_o, regb_o and regd_o SHALL load entry {rd_thr_i, addr} at the clock edge; read latency is 1 cycle.
REQ-024 With ena_i=0, the outputs SHALL hold and no writeback SHALL occur.
REQ-025 A write SHALL occur when ena_i=1, the FSM is in RUN, wr_i is not 0 and wr_src_i is in {0,1,2,3}.
REQ-026 Writeback data SHALL be selected as: src 0 gives res_i; src 1 gives {pclnk_i, 2'b00}; src 2 gives the resized load; src 3 gives mul_i.
REQ-027 Register r0 SHALL read 0 in every thread; writes to r0 are discarded.
REQ-028 Forwarding: when a write and a read hit the same {thread, addr} in the same cycle, the output SHALL capture the new write data.
REQ-029 The load latch SHALL capture dwb_dat_i whenever dwb_ack_i=1, independent of ena_i, in RUN.
REQ-030 Load resizer, byte lanes: sel 8/4/2/1 select bits [31:24]/[23:16]/[15:8]/[7:0] respectively.
REQ-031 Load resizer, halfwords: sel C selects bits [31:16] and sel 3 selects bits [15:0].
REQ-032 Load resizer, word: sel F selects the whole latch.
REQ-033 Load resizer, extension: sub-word results are zero-extended, or sign-extended when SEXT_EN=1 and sext_i=1; any other sel value gives 0.
REQ-034 Writes from different threads SHALL never alias; each thread's bank is fully independent.

Reset
REQ-035 rst_i assertion, including mid-sweep or mid-writeback, SHALL immediately clear the outputs, the load latch and the counter, and set busy_o=1; the sweep restarts from entry 0.
REQ-036 Register contents are only guaranteed to be 0 after busy_o falls.

Structure
REQ-037 The writeback source encodings, FSM state encodings and the register count (32) SHALL be constants in the shared aemb2 package.
REQ-038 The load resizer SHALL be a sub-module, aemb2_ldsz (combinational, sel/sext to data).
REQ-039 Register storage SHALL be inferable as distributed RAM, with one write port and three read ports.

Verification
REQ-040 Reset, then count: busy_o=1 for exactly 64 cycles (THR_W=1), then 0, and every register reads 0.
REQ-041 Write r5 in thread 1 with src 0, res_i=0xDEADBEEF: thread 1 r5 reads 0xDEADBEEF, and thread 0 r5 reads 0.
REQ-042 Same-cycle write and read of r7 with mul_i=0x12345678: rega_o=0x12345678 on the next cycle (forwarding).
REQ-043 Write r0 with 0xFFFFFFFF: reads return 0.
REQ-044 dwb_dat_i=0x80C1_7F02 with ack, then load writes: sel 8 + sext gives 0xFFFFFF80; sel 3 gives 0x00007F02; sel C + sext gives 0xFFFF80C1.
REQ-045 Assert rst_i at sweep cycle 20: busy_o stays 1 for 64 further cycles, and the outputs are 0 throughout.

Source files
------------

// File: rtl/aemb2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aemb2_pkg
// Description : Shared constants, FSM encoding and load-extension helpers
//               for the AEMB2 register file.
// Revision    : 1.0
// ============================================================================
package aemb2_pkg;

    localparam int REG_NUM = 32;

    localparam logic [2:0] WB_ALU  = 3'd0;
    localparam logic [2:0] WB_LNK  = 3'd1;
    localparam logic [2:0] WB_LD   = 3'd2;
    localparam logic [2:0] WB_MUL  = 3'd3;
    localparam logic [2:0] WB_NONE = 3'd7;

    typedef enum logic [0:0] {
        ST_SWEEP = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    function automatic logic [31:0] f_ext8(input logic [7:0] b, input logic ext);
        return {{24{ext & b[7]}}, b};
    endfunction

    function automatic logic [31:0] f_ext16(input logic [15:0] h, input logic ext);
        return {{16{ext & h[15]}}, h};
    endfunction

endpackage
`default_nettype wire

// File: rtl/aemb2_ldsz.sv
`default_nettype none
// ============================================================================
// Module      : aemb2_ldsz
// Description : Combinational load resizer: lane select plus zero/sign extend.
// Revision    : 1.0
// ============================================================================
module aemb2_ldsz
    import aemb2_pkg::*;
#(
    parameter bit SEXT_EN = 1'b1
)(
    input  logic [31:0] dat_i,
    input  logic [3:0]  sel_i,
    input  logic        sext_i,
    output logic [31:0] dat_o
);

    logic w_ext;
    assign w_ext = SEXT_EN & sext_i;

    always_comb begin
        dat_o = '0;
        case (sel_i)
            4'h8:    dat_o = f_ext8(dat_i[31:24], w_ext);
            4'h4:    dat_o = f_ext8(dat_i[23:16], w_ext);
            4'h2:    dat_o = f_ext8(dat_i[15:8],  w_ext);
            4'h1:    dat_o = f_ext8(dat_i[7:0],   w_ext);
            4'hC:    dat_o = f_ext16(dat_i[31:16], w_ext);
            4'h3:    dat_o = f_ext16(dat_i[15:0],  w_ext);
            4'hF:    dat_o = dat_i;
            default: dat_o = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/aemb2_xregf.sv
`default_nettype none
// ============================================================================
// Module      : aemb2_xregf
// Description : Multi-thread register file, 3 registered read ports, one
//               writeback port, and a clear sweep after reset.
// Revision    : 1.0
// ============================================================================
module aemb2_xregf
    import aemb2_pkg::*;
#(
    parameter int THR_W   = 1,
    parameter bit SEXT_EN = 1'b1
)(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ena_i,
    input  logic [THR_W-1:0]  rd_thr_i,
    input  logic [4:0]        ra_i,
    input  logic [4:0]        rb_i,
    input  logic [4:0]        rd_i,
    output logic [31:0]       rega_o,
    output logic [31:0]       regb_o,
    output logic [31:0]       regd_o,
    input  logic [THR_W-1:0]  wr_thr_i,
    input  logic [4:0]        wr_i,
    input  logic [2:0]        wr_src_i,
    input  logic [31:0]       res_i,
    input  logic [31:0]       mul_i,
    input  logic [31:2]       pclnk_i,
    input  logic [3:0]        sel_i,
    input  logic              sext_i,
    input  logic [31:0]       dwb_dat_i,
    input  logic              dwb_ack_i,
    output logic              busy_o
);

    localparam int          c_AW    = THR_W + 5;
    localparam int          c_DEPTH = REG_NUM << THR_W;
    localparam logic [c_AW-1:0] c_LAST = c_AW'(c_DEPTH - 1);

    state_t          r_state;
    state_t          w_stateNext;
    logic [c_AW-1:0] r_sweepCnt;
    logic [31:0]     r_ldLatch;
    logic [31:0]     r_mem [0:c_DEPTH-1];
    logic [31:0]     r_opnd [3];

    logic            w_run;
    logic [31:0]     w_ldData;
    logic [31:0]     w_wbData;
    logic            w_wbEn;
    logic [c_AW-1:0] w_wbAddr;
    logic            w_memWe;
    logic [c_AW-1:0] w_memAddr;
    logic [31:0]     w_memDat;
    logic [4:0]      w_rdAddr [3];
    logic [31:0]     w_rdData [3];

    assign w_run  = (r_state == ST_RUN);
    assign busy_o = ~w_run;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= ST_SWEEP;
            r_sweepCnt <= '0;
        end else begin
            r_state <= w_stateNext;
            if (!w_run)
                r_sweepCnt <= r_sweepCnt + 1'b1;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        if (r_state == ST_SWEEP && r_sweepCnt == c_LAST)
            w_stateNext = ST_RUN;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            r_ldLatch <= '0;
        else if (w_run && dwb_ack_i)
            r_ldLatch <= dwb_dat_i;
    end

    aemb2_ldsz #(.SEXT_EN(SEXT_EN)) u_ldsz (
        .dat_i  (r_ldLatch),
        .sel_i  (sel_i),
        .sext_i (sext_i),
        .dat_o  (w_ldData)
    );

    always_comb begin
        w_wbData = '0;
        w_wbEn   = 1'b0;
        case (wr_src_i)
            WB_ALU: begin w_wbData = res_i;            w_wbEn = 1'b1; end
            WB_LNK: begin w_wbData = {pclnk_i, 2'b00}; w_wbEn = 1'b1; end
            WB_LD:  begin w_wbData = w_ldData;         w_wbEn = 1'b1; end
            WB_MUL: begin w_wbData = mul_i;            w_wbEn = 1'b1; end
            default: ;
        endcase
        w_wbEn = w_wbEn && w_run && ena_i && (wr_i != 5'd0);
    end

    assign w_wbAddr = {wr_thr_i, wr_i};

    // The sweep owns the single write port until every entry is cleared.
    assign w_memWe   = ~w_run | w_wbEn;
    assign w_memAddr = w_run ? w_wbAddr : r_sweepCnt;
    assign w_memDat  = w_run ? w_wbData : 32'd0;

    always_ff @(posedge clk_i) begin
        if (w_memWe)
            r_mem[w_memAddr] <= w_memDat;
    end

    assign w_rdAddr[0] = ra_i;
    assign w_rdAddr[1] = rb_i;
    assign w_rdAddr[2] = rd_i;

    generate
        for (genvar p = 0; p < 3; p++) begin : g_rdPort
            logic [c_AW-1:0] w_full;
            assign w_full = {rd_thr_i, w_rdAddr[p]};
            // r0 is hard zero; a same-cycle write to the read entry is forwarded.
            assign w_rdData[p] = (w_rdAddr[p] == 5'd0)              ? 32'd0    :
                                 (w_wbEn && (w_wbAddr == w_full))   ? w_wbData :
                                                                      r_mem[w_full];
        end
    endgenerate

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 3; i++)
                r_opnd[i] <= '0;
        end else if (w_run && ena_i) begin
            for (int i = 0; i < 3; i++)
                r_opnd[i] <= w_rdData[i];
        end
    end

    assign rega_o = r_opnd[0];
    assign regb_o = r_opnd[1];
    assign regd_o = r_opnd[2];

endmodule
`default_nettype wire

// File: tb/tb_aemb2_xregf.sv
`default_nettype none
// ============================================================================
// Module      : tb_aemb2_xregf
// Description : Directed self-checking bench for aemb2_xregf (THR_W=1).
// Revision    : 1.0
// ============================================================================
module tb_aemb2_xregf;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        ena_i = 1'b0;
    logic [0:0]  rd_thr_i = '0;
    logic [4:0]  ra_i = '0, rb_i = '0, rd_i = '0;
    logic [31:0] rega_o, regb_o, regd_o;
    logic [0:0]  wr_thr_i = '0;
    logic [4:0]  wr_i = '0;
    logic [2:0]  wr_src_i = 3'd7;
    logic [31:0] res_i = '0, mul_i = '0;
    logic [31:2] pclnk_i = '0;
    logic [3:0]  sel_i = '0;
    logic        sext_i = 1'b0;
    logic [31:0] dwb_dat_i = '0;
    logic        dwb_ack_i = 1'b0;
    logic        busy_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    aemb2_xregf #(.THR_W(1), .SEXT_EN(1'b1)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .ena_i(ena_i), .rd_thr_i(rd_thr_i),
        .ra_i(ra_i), .rb_i(rb_i), .rd_i(rd_i),
        .rega_o(rega_o), .regb_o(regb_o), .regd_o(regd_o),
        .wr_thr_i(wr_thr_i), .wr_i(wr_i), .wr_src_i(wr_src_i),
        .res_i(res_i), .mul_i(mul_i), .pclnk_i(pclnk_i),
        .sel_i(sel_i), .sext_i(sext_i),
        .dwb_dat_i(dwb_dat_i), .dwb_ack_i(dwb_ack_i), .busy_o(busy_o)
    );

    task automatic do_write(input logic thr, input logic [4:0] a,
                            input logic [2:0] src, input logic [31:0] d);
        @(negedge clk_i);
        ena_i = 1'b1; wr_thr_i = thr; wr_i = a; wr_src_i = src;
        res_i = d; mul_i = d;
        @(posedge clk_i); #1;
        wr_src_i = 3'd7;
    endtask

    task automatic do_read(input logic thr, input logic [4:0] a,
                           input logic [4:0] b, input logic [4:0] d);
        @(negedge clk_i);
        ena_i = 1'b1; wr_src_i = 3'd7; rd_thr_i = thr;
        ra_i = a; rb_i = b; rd_i = d;
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    // Counts clock edges until busy_o falls; also reports whether the
    // outputs stayed zero throughout.
    task automatic sweep_count(output int n, output bit allZero);
        n = 0; allZero = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk_i); n++;
            @(negedge clk_i);
            if (rega_o !== 0 || regb_o !== 0 || regd_o !== 0) allZero = 1'b0;
            if (busy_o !== 1'b1) break;
        end
    endtask

    task automatic test_reset;
        int n; bit z;
        #1;
        checks++;
        if (busy_o !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b want 1", busy_o); end
        checks++;
        if (rega_o !== 0) begin errors++; $display("FAIL reset_rega: got %h want 0", rega_o); end
        // Writebacks and reads presented during the sweep must be ignored.
        ena_i = 1'b1; wr_thr_i = 1'b0; wr_i = 5'd5; wr_src_i = 3'd0;
        res_i = 32'hAAAA5555; ra_i = 5'd5; rb_i = 5'd5; rd_i = 5'd5;
        @(negedge clk_i); rst_i = 1'b0;
        sweep_count(n, z);
        wr_src_i = 3'd7;
        checks++;
        if (n !== 64) begin errors++; $display("FAIL sweep_len: got %0d want 64", n); end
        checks++;
        if (z !== 1'b1) begin errors++; $display("FAIL sweep_outputs_zero: got %b want 1", z); end
        checks++;
        if (busy_o !== 1'b0) begin errors++; $display("FAIL busy_after_sweep: got %b want 0", busy_o); end
        for (int t = 0; t < 2; t++) begin
            for (int r = 0; r < 32; r += 3) begin
                do_read(t[0], r[4:0], 5'((r + 1) % 32), 5'((r + 2) % 32));
                checks++;
                if (rega_o !== 0 || regb_o !== 0 || regd_o !== 0) begin
                    errors++;
                    $display("FAIL cleared t%0d r%0d: got %h %h %h want 0", t, r, rega_o, regb_o, regd_o);
                end
            end
        end
    endtask

    task automatic test_thread_iso;
        do_write(1'b1, 5'd5, 3'd0, 32'hDEADBEEF);
        do_read(1'b1, 5'd5, 5'd0, 5'd5);
        checks++;
        if (rega_o !== 32'hDEADBEEF) begin errors++; $display("FAIL t1_r5: got %h want deadbeef", rega_o); end
        checks++;
        if (regd_o !== 32'hDEADBEEF) begin errors++; $display("FAIL t1_r5_portd: got %h want deadbeef", regd_o); end
        do_read(1'b0, 5'd5, 5'd5, 5'd5);
        checks++;
        if (regb_o !== 32'h0) begin errors++; $display("FAIL t0_r5: got %h want 0", regb_o); end
    endtask

    task automatic test_forward;
        @(negedge clk_i);
        ena_i = 1'b1; wr_thr_i = 1'b0; wr_i = 5'd7; wr_src_i = 3'd3;
        mul_i = 32'h12345678; res_i = 32'h0;
        rd_thr_i = 1'b0; ra_i = 5'd7; rb_i = 5'd0; rd_i = 5'd0;
        @(posedge clk_i); #1; wr_src_i = 3'd7;
        @(negedge clk_i);
        checks++;
        if (rega_o !== 32'h12345678) begin errors++; $display("FAIL forward_r7: got %h want 12345678", rega_o); end
    endtask

    task automatic test_r0;
        do_write(1'b0, 5'd0, 3'd0, 32'hFFFFFFFF);
        do_read(1'b0, 5'd0, 5'd0, 5'd0);
        checks++;
        if (rega_o !== 32'h0) begin errors++; $display("FAIL r0_read: got %h want 0", rega_o); end
        @(negedge clk_i);
        wr_thr_i = 1'b1; wr_i = 5'd0; wr_src_i = 3'd0; res_i = 32'hFFFFFFFF;
        rd_thr_i = 1'b1; ra_i = 5'd0;
        @(posedge clk_i); #1; wr_src_i = 3'd7;
        @(negedge clk_i);
        checks++;
        if (rega_o !== 32'h0) begin errors++; $display("FAIL r0_forward: got %h want 0", rega_o); end
    endtask

    task automatic test_load;
        logic [3:0]  sels [6] = '{4'h8, 4'h3, 4'hC, 4'hF, 4'h4, 4'h5};
        logic        exts [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [31:0] exps [6] = '{32'hFFFFFF80, 32'h00007F02, 32'hFFFF80C1,
                                  32'h80C17F02, 32'hFFFFFFC1, 32'h0};
        @(negedge clk_i);
        ena_i = 1'b0; dwb_dat_i = 32'h80C17F02; dwb_ack_i = 1'b1;
        @(posedge clk_i); #1;
        dwb_ack_i = 1'b0; dwb_dat_i = 32'h0;
        for (int i = 0; i < 6; i++) begin
            sel_i = sels[i]; sext_i = exts[i];
            do_write(1'b0, 5'(10 + i), 3'd2, 32'h0);
        end
        for (int i = 0; i < 6; i++) begin
            do_read(1'b0, 5'(10 + i), 5'd0, 5'd0);
            checks++;
            if (rega_o !== exps[i]) begin
                errors++;
                $display("FAIL load sel=%h sext=%b: got %h want %h", sels[i], exts[i], rega_o, exps[i]);
            end
        end
        pclnk_i = 30'h048D159E;
        do_write(1'b1, 5'd9, 3'd1, 32'h0);
        do_read(1'b1, 5'd0, 5'd9, 5'd0);
        checks++;
        if (regb_o !== 32'h12345678) begin errors++; $display("FAIL link_pc: got %h want 12345678", regb_o); end
        do_write(1'b1, 5'd9, 3'd4, 32'h55555555);
        do_read(1'b1, 5'd0, 5'd9, 5'd0);
        checks++;
        if (regb_o !== 32'h12345678) begin errors++; $display("FAIL src4_nowrite: got %h want 12345678", regb_o); end
    endtask

    task automatic test_hold;
        do_read(1'b1, 5'd5, 5'd9, 5'd0);
        @(negedge clk_i);
        ena_i = 1'b0; rd_thr_i = 1'b0; ra_i = 5'd7; rb_i = 5'd0;
        wr_thr_i = 1'b1; wr_i = 5'd5; wr_src_i = 3'd0; res_i = 32'h0BADF00D;
        @(posedge clk_i); @(negedge clk_i);
        wr_src_i = 3'd7;
        checks++;
        if (rega_o !== 32'hDEADBEEF || regb_o !== 32'h12345678) begin
            errors++; $display("FAIL hold: got %h %h want deadbeef 12345678", rega_o, regb_o);
        end
        do_read(1'b1, 5'd5, 5'd0, 5'd0);
        checks++;
        if (rega_o !== 32'hDEADBEEF) begin errors++; $display("FAIL no_write_when_idle: got %h want deadbeef", rega_o); end
    endtask

    task automatic test_reset_mid;
        int n; bit z;
        do_read(1'b1, 5'd5, 5'd5, 5'd5);
        ena_i = 1'b0;
        #2 rst_i = 1'b1; #1;
        checks++;
        if (rega_o !== 0 || regb_o !== 0 || regd_o !== 0 || busy_o !== 1'b1) begin
            errors++; $display("FAIL async_reset_run: got %h %h %h busy=%b want 0 0 0 1", rega_o, regb_o, regd_o, busy_o);
        end
        @(negedge clk_i); rst_i = 1'b0;
        repeat (20) @(posedge clk_i);
        #2 rst_i = 1'b1; #1;
        checks++;
        if (busy_o !== 1'b1 || rega_o !== 0) begin errors++; $display("FAIL reset_mid_sweep: got busy=%b a=%h want 1 0", busy_o, rega_o); end
        @(negedge clk_i); rst_i = 1'b0;
        sweep_count(n, z);
        checks++;
        if (n !== 64) begin errors++; $display("FAIL resweep_len: got %0d want 64", n); end
        checks++;
        if (z !== 1'b1) begin errors++; $display("FAIL resweep_zero: got %b want 1", z); end
        do_read(1'b1, 5'd5, 5'd9, 5'd0);
        checks++;
        if (rega_o !== 0 || regb_o !== 0) begin errors++; $display("FAIL cleared_after_resweep: got %h %h want 0 0", rega_o, regb_o); end
    endtask

    initial begin
        test_reset;
        test_thread_iso;
        test_forward;
        test_r0;
        test_load;
        test_hold;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
